// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store onto an 8-bit RAM port.
// Reads complete N+2 cycles after acceptance and stores N+1 cycles after; requesters hold until their ready pulse.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              flush,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            r_state;
    logic              r_src_ls;
    logic              r_last_ls;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_n;
    logic [2:0]        r_cnt;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;

    logic              w_if_ok;
    logic              w_grant_ls;
    logic              w_accept;
    logic [2:0]        w_ls_n;
    logic [2:0]        w_next_k;
    logic [ADDR_W-1:0] w_next_a;
    logic [1:0]        w_bidx;
    logic [31:0]       w_asm;

    always_comb begin
        w_if_ok    = if_req & ~flush;
        w_grant_ls = ls_req & (~w_if_ok | ~r_last_ls);
        w_accept   = w_if_ok | ls_req;
        case (ls_size)
            2'b00:   w_ls_n = 3'd1;
            2'b01:   w_ls_n = 3'd2;
            default: w_ls_n = 3'd4;
        endcase
        w_next_k = r_cnt + 3'd1;
        w_next_a = r_base + ADDR_W'(w_next_k);
        // In READ, cycle r_cnt carries the byte addressed in cycle r_cnt-1.
        w_bidx   = r_cnt[1:0] - 2'd1;
        w_asm    = r_buf;
        w_asm[{w_bidx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_src_ls  <= 1'b0;
            r_last_ls <= 1'b0;
            r_base    <= '0;
            r_n       <= 3'd0;
            r_cnt     <= 3'd0;
            r_wdata   <= 32'd0;
            r_buf     <= 32'd0;
            if_ready  <= 1'b0;
            ls_ready  <= 1'b0;
            if_data   <= 32'd0;
            ls_rdata  <= 32'd0;
            mem_a     <= '0;
            mem_dout  <= 8'd0;
            mem_wr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_src_ls  <= w_grant_ls;
                        r_last_ls <= w_grant_ls;
                        r_cnt     <= 3'd0;
                        r_buf     <= 32'd0;
                        if (w_grant_ls) begin
                            r_base  <= ls_addr;
                            mem_a   <= ls_addr;
                            r_n     <= w_ls_n;
                            r_wdata <= ls_wdata;
                            if (ls_we) begin
                                r_state  <= WRITE;
                                mem_wr   <= 1'b1;
                                mem_dout <= ls_wdata[7:0];
                            end else begin
                                r_state <= READ;
                            end
                        end else begin
                            r_base  <= if_addr;
                            mem_a   <= if_addr;
                            r_n     <= 3'd4;
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    if (flush && !r_src_ls) begin
                        mem_a   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_next_k;
                        if (r_cnt != 3'd0)
                            r_buf <= w_asm;
                        mem_a <= (w_next_k < r_n) ? w_next_a : '0;
                        if (r_cnt == r_n) begin
                            r_state <= DONE;
                            if (r_src_ls) begin
                                ls_rdata <= w_asm;
                                ls_ready <= 1'b1;
                            end else begin
                                if_data  <= w_asm;
                                if_ready <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    r_cnt <= w_next_k;
                    if (w_next_k < r_n) begin
                        mem_a    <= w_next_a;
                        mem_dout <= r_wdata[{w_next_k[1:0], 3'b000} +: 8];
                    end else begin
                        mem_a    <= '0;
                        mem_dout <= 8'd0;
                        mem_wr   <= 1'b0;
                        ls_ready <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    // Requests still high on this edge are deliberately not accepted.
                    if_ready <= 1'b0;
                    ls_ready <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-addressed RAM model, transaction-level expected traces, vector table and random traffic.
module tb_mem_ctrl;

    typedef struct {
        bit          src_ls;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          fl;
        bit          hold;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic        if_ready, ls_ready, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;

    logic [7:0]  ram [0:4095];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_if = 32'd0;
    logic [31:0] exp_ls = 32'd0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .flush(flush),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM: read data one cycle after the address, writes on the strobe edge.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) ram[mem_a[11:0]] = mem_dout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drop_reqs();
        if_req = 1'b0;
        ls_req = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_a"}, mem_a, 32'd0);
        chk({tag, " mem_wr"}, 32'(mem_wr), 32'd0);
        chk({tag, " mem_dout"}, 32'(mem_dout), 32'd0);
        chk({tag, " if_ready"}, 32'(if_ready), 32'd0);
        chk({tag, " ls_ready"}, 32'(ls_ready), 32'd0);
    endtask

    // Called at a falling edge with the controller idle; checks every cycle of one transaction.
    task automatic run_txn(input vec_t v, input bit use_tbl, input bit rival, input string tag);
        int          n, last;
        bit          is_wr;
        logic [31:0] exp_d, ea;
        logic [7:0]  ed;
        bit          ew;
        is_wr = v.src_ls && v.we;
        n     = !v.src_ls ? 4 : (v.size == 2'b00 ? 1 : (v.size == 2'b01 ? 2 : 4));
        last  = is_wr ? n + 1 : n + 2;
        exp_d = 32'd0;
        if (use_tbl) exp_d = v.exp_data;
        else for (int k = 0; k < n; k++) exp_d |= 32'(ram[12'(v.addr + 32'(k))]) << (8 * k);
        if (v.src_ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
            flush = v.fl; if_req = rival; if_addr = 32'h0000_0800;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 1; c <= last; c++) begin
            tick();
            ea = 32'd0; ew = 1'b0; ed = 8'd0;
            if (c <= n) begin
                ea = v.addr + 32'(c - 1);
                ew = is_wr;
                ed = is_wr ? 8'(v.wdata >> (8 * (c - 1))) : 8'd0;
            end
            if (c == last) begin
                if (!v.src_ls) exp_if = exp_d;
                else if (!is_wr) exp_ls = exp_d;
            end
            chk($sformatf("%s c%0d mem_a", tag, c), mem_a, ea);
            chk($sformatf("%s c%0d mem_wr", tag, c), 32'(mem_wr), 32'(ew));
            chk($sformatf("%s c%0d mem_dout", tag, c), 32'(mem_dout), 32'(ed));
            chk($sformatf("%s c%0d if_ready", tag, c), 32'(if_ready), 32'(c == last && !v.src_ls));
            chk($sformatf("%s c%0d ls_ready", tag, c), 32'(ls_ready), 32'(c == last && v.src_ls));
            chk($sformatf("%s c%0d if_data", tag, c), if_data, exp_if);
            chk($sformatf("%s c%0d ls_rdata", tag, c), ls_rdata, exp_ls);
            if (c == 1 && v.src_ls) if_req = 1'b0;
            if (c == last && !v.hold) drop_reqs();
        end
        tick();
        chk_quiet({tag, " post"});
        drop_reqs();
    endtask

    initial begin
        vec_t        tbl [12];
        vec_t        v;
        int          got, cyc;

        for (int i = 0; i < 4096; i++) ram[i] = 8'(i);
        tbl[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'h1312_1110};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 32'h0000_00A5, 32'h0,         1'b0, 1'b0, 32'h0000_00A5};
        tbl[2]  = '{1'b1, 1'b0, 2'b01, 32'h0000_007F, 32'h0,         1'b1, 1'b0, 32'h0000_807F};
        tbl[3]  = '{1'b1, 1'b1, 2'b01, 32'h0000_2000, 32'hAABB_CCDD, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0,         1'b0, 1'b1, 32'h0302_CCDD};
        tbl[5]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0030, 32'h1234_5677, 1'b1, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 2'b11, 32'h0000_002E, 32'h0,         1'b0, 1'b0, 32'h3177_2F2E};
        tbl[7]  = '{1'b1, 1'b1, 2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0040, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[9]  = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE, 32'h0,         1'b0, 1'b1, 32'hCCDD_FFFE};
        tbl[10] = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         1'b0, 1'b0, 32'hCCDD_FFFE};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 32'h0000_0FFF, 32'h0,         1'b0, 1'b0, 32'h0000_00FF};

        // Reset with both requesters already pending: grants must alternate starting with LS.
        rst = 1'b0; flush = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h0000_0300; ls_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset if_data", if_data, 32'd0);
        chk("reset ls_rdata", ls_rdata, 32'd0);
        rst = 1'b1;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 80) begin
            tick();
            cyc++;
            if (if_ready || ls_ready) begin
                chk($sformatf("arb grant%0d ls_ready", got), 32'(ls_ready), (got % 2 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("arb grant%0d if_ready", got), 32'(if_ready), (got % 2 == 0) ? 32'd0 : 32'd1);
                if (got == 3) drop_reqs();
                got++;
            end
        end
        chk("arb grant count", 32'(got), 32'd4);
        drop_reqs();
        tick();
        exp_if = 32'h0302_0100;
        exp_ls = 32'h0000_0000;
        chk("arb if_data", if_data, exp_if);
        chk("arb ls_rdata", ls_rdata, exp_ls);

        for (int i = 0; i < 12; i++) run_txn(tbl[i], 1'b1, tbl[i].fl, $sformatf("tbl%0d", i));

        // Instruction word assembled little-endian.
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        v = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0000_0513};
        run_txn(v, 1'b1, 1'b0, "ifword");

        // Flush mid fetch, then flush blocking a lone IF request in IDLE.
        if_req = 1'b1; if_addr = 32'h0000_0400;
        tick();
        chk("flush A+1 mem_a", mem_a, 32'h0000_0400);
        tick();
        tick();
        chk("flush A+3 mem_a", mem_a, 32'h0000_0402);
        flush = 1'b1;
        tick();
        chk_quiet("flush A+4");
        tick();
        chk_quiet("flush blocked");
        drop_reqs();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("flush after%0d if_ready", i), 32'(if_ready), 32'd0);
        end
        chk("flush if_data held", if_data, exp_if);
        v = '{1'b1, 1'b0, 2'b00, 32'h0000_04C5, 32'h0, 1'b0, 1'b0, 32'h0000_00C5};
        run_txn(v, 1'b1, 1'b0, "postflush");

        for (int i = 0; i < 40; i++) begin
            v.src_ls   = ($urandom_range(0, 2) != 0);
            v.we       = v.src_ls && ($urandom_range(0, 1) == 1);
            v.size     = 2'($urandom_range(0, 3));
            v.addr     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            v.wdata    = $urandom;
            v.fl       = v.src_ls && ($urandom_range(0, 1) == 1);
            v.hold     = ($urandom_range(0, 1) == 1);
            v.exp_data = 32'd0;
            run_txn(v, 1'b0, v.fl && ($urandom_range(0, 1) == 1), $sformatf("rnd%0d", i));
        end

        // Reset during the second byte of a word store.
        ram[12'h501] = 8'h5A;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h0000_0500; ls_wdata = 32'h1122_3344;
        tick();
        chk("rststore k0 mem_wr", 32'(mem_wr), 32'd1);
        tick();
        chk("rststore k1 mem_a", mem_a, 32'h0000_0501);
        #2 rst = 1'b0;
        #1;
        chk_quiet("rststore async");
        chk("rststore if_data", if_data, 32'd0);
        chk("rststore ls_rdata", ls_rdata, 32'd0);
        drop_reqs();
        exp_if = 32'd0;
        exp_ls = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_quiet($sformatf("rststore after%0d", i));
        end
        chk("rststore ram 0x500", 32'(ram[12'h500]), 32'h44);
        chk("rststore ram 0x501", 32'(ram[12'h501]), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 clk  in  1  single system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetcher request for a 32-bit instruction word; held until if_ready.
REQ-005 if_addr  in  ADDR_W  fetch byte address; stable while if_req is high.
REQ-006 if_ready  out  1  one-cycle pulse; if_data valid.
REQ-007 if_data  out  32  assembled instruction, little-endian.
REQ-008 flush  in  1  branch redirect; cancels any IF transaction.
REQ-009 ls_req  in  1  load/store request; held until ls_ready.
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_size  in  2  00 byte, 01 half, 10 or 11 word.
REQ-012 ls_addr  in  ADDR_W  load/store byte address.
REQ-013 ls_wdata  in  32  store data; low bytes used.
REQ-014 ls_ready  out  1  one-cycle pulse; load data valid or store complete.
REQ-015 ls_rdata  out  32  load data, zero-extended.
REQ-016 mem_din  in  8  RAM read byte; valid one cycle after its address.
REQ-017 mem_dout  out  8  RAM write byte.
REQ-018 mem_a  out  ADDR_W  RAM byte address.
REQ-019 mem_wr  out  1  RAM write strobe.

Function
REQ-020 The FSM SHALL have four states: IDLE, READ, WRITE, DONE.
REQ-021 Byte count N: 1 for byte, 2 for half, 4 for word/11, 4 for IF.
REQ-022 Acceptance occurs only on an edge in IDLE with a request pending; the base address, N, the source and (for stores) the data are latched at acceptance.
REQ-023 Arbitration: if only one requester is pending, grant it; if both are pending, grant the one not served last; the last-served flag updates at each acceptance.
REQ-024 Read (IF, or LS with ls_we=0): in cycle A+1+k (k=0..N-1, A = acceptance edge), mem_a = base+k and mem_wr=0; byte k is captured from mem_din at the end of cycle A+2+k into bits [8k+7:8k].
REQ-025 After the last byte is captured, the FSM SHALL enter DONE for exactly one cycle, with ready and data valid; a word read therefore has ready in cycle A+6 and a byte read in cycle A+3.
REQ-026 Store: in cycle A+1+k, mem_a = base+k, mem_wr=1 and mem_dout = ls_wdata[8k+7:8k]; DONE with ls_ready follows in cycle A+N+1.
REQ-027 Outside READ/WRITE address cycles: mem_wr=0, mem_a=0 and mem_dout=0.
REQ-028 Only the granted source's ready pulses; the other ready stays 0.
REQ-029 if_data/ls_rdata SHALL hold their last value until the next completion of the same source; unused upper bytes are 0.
REQ-030 Address arithmetic wraps modulo 2^ADDR_W.
REQ-031 A request that is still high on the edge ending DONE is not accepted on that edge; the FSM returns to IDLE.
REQ-032 flush high on any edge during an IF READ or IF DONE SHALL return the FSM to IDLE, with no if_ready pulse afterward and if_data unchanged.
REQ-033 flush SHALL block IF acceptance on that edge (an LS request may still be granted) and SHALL NOT affect LS transactions.
REQ-034 flush asserted on the same edge as a pending IF-only acceptance: no acceptance; the FSM stays in IDLE.

Reset
REQ-035 rst low SHALL immediately force IDLE and clear the latches.
REQ-036 Reset values: if_ready=0, ls_ready=0, if_data=0, ls_rdata=0, mem_a=0, mem_dout=0, mem_wr=0, last-served=IF.
REQ-037 A transaction interrupted by reset SHALL be abandoned with no ready pulse; operation resumes on the first edge with rst high.

Verification
REQ-038 IF word at 0x100, RAM bytes 13,05,00,00 -> mem_a 0x100..0x103 in cycles A+1..A+4; if_ready in A+6 with if_data=0x00000513.
REQ-039 Store half, ls_addr=0x2000, ls_wdata=0xAABBCCDD -> writes 0xDD@0x2000 and 0xCC@0x2001; ls_ready in A+3; no other mem_wr.
REQ-040 if_req and ls_req both high from reset, held back-to-back -> grants alternate LS, IF, LS, IF.
REQ-041 flush in cycle A+3 of an IF read -> no if_ready; an LS byte load then accepted from IDLE completes with ls_rdata=0x000000xx.
REQ-042 rst low mid-store at k=1 -> mem_wr=0 immediately; no ls_ready; all outputs 0.
REQ-043 Load word at 0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
